mem_port_arbiter: RTL and testbench

//  Shares one single-port synchronous memory between instruction fetch (IF, read-only) and the

---
 rtl/mem_port_if.sv | 62 ++++++
 rtl/mem_port_arbiter.sv | 102 ++++++++++
 tb/tb_mem_port_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mem_port_if.sv
// ---------------------------------------------------------------------------
// mem_port_if
// Bundles the request/grant/response signals for both requesters (instruction
// fetch and data memory) and the single-port synchronous memory they share.
//
//   if_req/if_addr            fetch request and address (PC)
//   if_gnt/if_stall           fetch owns the port this cycle / fetch is waiting
//   if_valid/if_q             fetched data, one cycle after if_gnt
//   dm_req/dm_we/dm_addr/
//   dm_wdata                  data request, write enable, address, write data
//   dm_gnt/dm_stall           data stage owns the port / data stage is waiting
//   dm_valid/dm_q             read data or write ack, one cycle after dm_gnt
//   mem_addr/mem_wdata/
//   mem_wren/mem_q            memory-side port
//
// Handshake: a requester raises *_req with stable address/data and holds it
// until *_gnt is seen high in the same cycle; the transfer is accepted on that
// clock edge and exactly one *_valid pulse follows on the next cycle. There is
// no back-pressure on the response side.
//
// slave  : the arbiter's view
// master : the pipeline + memory environment's view
// ---------------------------------------------------------------------------
interface mem_port_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [DATA_W-1:0] if_q;
    logic              if_stall;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_valid;
    logic [DATA_W-1:0] dm_q;
    logic              dm_stall;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_q,
        output if_gnt, if_valid, if_q, if_stall,
               dm_gnt, dm_valid, dm_q, dm_stall,
               mem_addr, mem_wdata, mem_wren
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_q,
        input  if_gnt, if_valid, if_q, if_stall,
               dm_gnt, dm_valid, dm_q, dm_stall,
               mem_addr, mem_wdata, mem_wren
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port synchronous memory between instruction fetch (IF,
// read-only) and the data-memory stage (DM, read/write). One requester is
// granted per cycle; DM wins ties unless it has already taken DM_STREAK_MAX
// consecutive grants while IF waited, in which case IF is forced through.
// The owner of each cycle is registered so the one-cycle-late memory output
// can be flagged as valid for the right requester.
//
// Ports:
//   i_clock       rising-edge clock
//   i_reset       asynchronous, active-high reset
//   io_bus        mem_port_if.slave (requests, grants, responses, memory port)
//   o_dbg_owner   registered owner of the previous cycle (0 none, 1 IF, 2 DM)
//   o_dbg_streak  consecutive DM grants taken while IF waited
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 8,
    parameter int DM_STREAK_MAX = 3
) (
    input  logic             i_clock,
    input  logic             i_reset,
    mem_port_if.slave        io_bus,
    output logic [1:0]       o_dbg_owner,
    output logic [3:0]       o_dbg_streak
);
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

    localparam logic [3:0] STREAK_MAX = 4'(DM_STREAK_MAX);

    owner_t            r_owner;
    logic [3:0]        r_streak;
    owner_t            w_owner_nxt;
    logic [3:0]        w_streak_nxt;

    logic              w_if_gnt;
    logic              w_dm_gnt;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    // State register
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_owner  <= OWN_NONE;
            r_streak <= '0;
        end else begin
            r_owner  <= w_owner_nxt;
            r_streak <= w_streak_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_owner_nxt  = OWN_NONE;
        w_streak_nxt = r_streak;
        if (w_if_gnt) begin
            w_owner_nxt = OWN_IF;
        end else if (w_dm_gnt) begin
            w_owner_nxt = OWN_DM;
        end
        // The streak only measures how long IF has been starved; it restarts
        // as soon as IF is served or stops asking.
        if (w_if_gnt || !io_bus.if_req) begin
            w_streak_nxt = '0;
        end else if (w_dm_gnt && (r_streak < STREAK_MAX)) begin
            w_streak_nxt = r_streak + 4'd1;
        end
    end

    // Output logic: grants and port mux are combinational on the current
    // requests; valids are decoded from the registered owner.
    always_comb begin
        w_if_gnt    = io_bus.if_req && (!io_bus.dm_req || (r_streak == STREAK_MAX));
        w_dm_gnt    = io_bus.dm_req && !w_if_gnt;
        // With no grant the address still follows the PC so an idle port
        // keeps presenting the next fetch address.
        w_mem_addr  = w_dm_gnt ? io_bus.dm_addr : io_bus.if_addr;
        w_mem_wdata = w_dm_gnt ? io_bus.dm_wdata : '0;
    end

    assign io_bus.if_gnt    = w_if_gnt;
    assign io_bus.dm_gnt    = w_dm_gnt;
    assign io_bus.if_stall  = io_bus.if_req & ~w_if_gnt;
    assign io_bus.dm_stall  = io_bus.dm_req & ~w_dm_gnt;
    assign io_bus.mem_addr  = w_mem_addr;
    assign io_bus.mem_wdata = w_mem_wdata;
    // Fetch grants never write.
    assign io_bus.mem_wren  = w_dm_gnt & io_bus.dm_we;

    assign io_bus.if_valid  = (r_owner == OWN_IF);
    assign io_bus.dm_valid  = (r_owner == OWN_DM);
    assign io_bus.if_q      = io_bus.mem_q;
    assign io_bus.dm_q      = io_bus.mem_q;

    assign o_dbg_owner      = r_owner;
    assign o_dbg_streak     = r_streak;
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int SMAX = 3;

  logic clk;
  logic rst;
  logic [1:0] dbg_owner;
  logic [3:0] dbg_streak;

  int checks = 0;
  int errors = 0;

  mem_port_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DM_STREAK_MAX(SMAX)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .io_bus       (bus),
    .o_dbg_owner  (dbg_owner),
    .o_dbg_streak (dbg_streak)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // physical memory behind the port: synchronous read, write on edge
  logic [DW-1:0] phys_mem [256];
  always @(posedge clk) begin
    if (bus.mem_wren) phys_mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_q <= phys_mem[bus.mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // reference model: what the port must do, in terms of requests and memory
  logic [DW-1:0] ref_mem [256];
  bit            pend_if, pend_dm, pend_rd;
  logic [DW-1:0] pend_data;
  int            if_waited;   // cycles IF has been refused in a row (model)
  int            dut_wait;    // consecutive if_stall cycles seen on the DUT
  bit            e_if, e_dm;

  always @(negedge clk) begin
    if (rst) begin
      pend_if = 0; pend_dm = 0; pend_rd = 0;
      if_waited = 0; dut_wait = 0;
      chk("rst_valids", {bus.if_valid, bus.dm_valid}, 2'b00);
    end else begin
      // responses for last cycle's grant
      chk("if_valid", bus.if_valid, pend_if);
      chk("dm_valid", bus.dm_valid, pend_dm);
      if (pend_if) chk("if_q", bus.if_q, pend_data);
      if (pend_dm && pend_rd) chk("dm_q", bus.dm_q, pend_data);

      // IF is refused only while DM asks and IF has waited fewer than SMAX cycles
      e_if = bus.if_req && (!bus.dm_req || if_waited >= SMAX);
      e_dm = bus.dm_req && !e_if;
      chk("if_gnt", bus.if_gnt, e_if);
      chk("dm_gnt", bus.dm_gnt, e_dm);
      chk("if_stall", bus.if_stall, bus.if_req && !e_if);
      chk("dm_stall", bus.dm_stall, bus.dm_req && !e_dm);
      chk("mem_wren", bus.mem_wren, e_dm && bus.dm_we);
      chk("mem_addr", bus.mem_addr, e_dm ? bus.dm_addr : bus.if_addr);
      if (e_dm && bus.dm_we) chk("mem_wdata", bus.mem_wdata, bus.dm_wdata);
      chk("one_gnt", bus.if_gnt && bus.dm_gnt, 1'b0);

      dut_wait = bus.if_stall ? dut_wait + 1 : 0;
      chk("if_wait_bound", dut_wait <= SMAX, 1'b1);

      // advance model
      pend_if = e_if;
      pend_dm = e_dm;
      pend_rd = e_dm && !bus.dm_we;
      pend_data = e_if ? ref_mem[bus.if_addr] : ref_mem[bus.dm_addr];
      if (e_dm && bus.dm_we) ref_mem[bus.dm_addr] = bus.dm_wdata;
      if_waited = (bus.if_req && !e_if) ? if_waited + 1 : 0;
    end
  end

  // driver: apply one cycle's requests, return just after the negedge
  task automatic step(input bit ir, input logic [AW-1:0] ia,
                      input bit dr, input bit we, input logic [AW-1:0] da,
                      input logic [DW-1:0] wd);
    @(posedge clk);
    #2;
    bus.if_req = ir; bus.if_addr = ia;
    bus.dm_req = dr; bus.dm_we = we; bus.dm_addr = da; bus.dm_wdata = wd;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 8'h00, 0, 0, 8'h00, 8'h00);
  endtask

  logic [7:0] gnt_pat;
  logic [7:0] exp_pat;

  initial begin
    rst = 1'b1;
    bus.if_req = 0; bus.if_addr = '0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      phys_mem[i] = (i < 16) ? 8'(8'hA0 + i) : 8'($urandom_range(0, 255));
      ref_mem[i] = phys_mem[i];
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      idle();
      chk("idle_outs", {bus.if_gnt, bus.dm_gnt, bus.if_valid, bus.dm_valid,
                        bus.mem_wren, bus.if_stall, bus.dm_stall}, 7'd0);
      chk("idle_state", {dbg_owner, dbg_streak}, 6'd0);
    end

    // 2: IF-only stream, fetched data known by construction (0xA0 + addr)
    for (int a = 0; a < 6; a++) begin
      step(1, 8'(a), 0, 0, 8'h00, 8'h00);
      chk("t2_gnt", {bus.if_gnt, bus.if_stall}, 2'b10);
      if (a > 0) chk("t2_q", {bus.if_valid, bus.if_q}, {1'b1, 8'(8'hA0 + a - 1)});
    end
    idle();
    chk("t2_last_q", {bus.if_valid, bus.if_q}, {1'b1, 8'hA5});

    // 3: write 0x3C to 0x80, read it back
    step(0, 8'h00, 1, 1, 8'h80, 8'h3C);
    chk("t3_wr", {bus.dm_gnt, bus.mem_wren}, 2'b11);
    step(0, 8'h00, 1, 0, 8'h80, 8'h00);
    chk("t3_rd", {bus.dm_gnt, bus.mem_wren, bus.dm_valid}, 3'b101);
    idle();
    chk("t3_q", {bus.dm_valid, bus.dm_q}, {1'b1, 8'h3C});

    // 4: both held 8 cycles -> DM,DM,DM,IF,DM,DM,DM,IF
    exp_pat = 8'b01110111;  // bit i = DM granted in cycle i
    for (int i = 0; i < 8; i++) begin
      step(1, 8'h01, 1, 0, 8'h02, 8'h00);
      gnt_pat[i] = bus.dm_gnt;
      chk("t4_stall", bus.if_stall, bus.dm_gnt);
    end
    chk("t4_order", gnt_pat, exp_pat);
    idle();

    // 5: reset with a DM read pending and a nonzero streak
    step(1, 8'h01, 1, 0, 8'h03, 8'h00);
    step(1, 8'h01, 1, 0, 8'h03, 8'h00);
    chk("t5_pre", {dbg_owner, dbg_streak}, {2'd2, 4'd1});
    @(posedge clk);
    #2;
    rst = 1'b1;
    bus.if_req = 0; bus.dm_req = 0;
    @(negedge clk);
    #1;
    chk("t5_rst", {bus.dm_valid, dbg_owner, dbg_streak}, 7'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    step(1, 8'h03, 0, 0, 8'h00, 8'h00);
    chk("t5_dm_valid", bus.dm_valid, 1'b0);
    idle();
    chk("t5_if_q", {bus.if_valid, bus.if_q}, {1'b1, 8'hA3});

    // 6: random traffic against the model
    for (int i = 0; i < 1000; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
           $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
